ex_muldiv_unit: RTL and testbench
=================================

Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage. It consumes the operands, no-op flag and decoded mul/div opcode that the ID/EX stage register presents to EX.
- Owns the HI/LO registers and executes MULT/MULTU/DIV/DIVU over 32 iterations, plus MTHI/MTLO in one cycle.
- Raises a stall request to hazard_unit when a later HI/LO-dependent instruction reaches EX before the unit is done.

Parameters:
- WIDTH, 32 (= `ISA_WIDTH), operand/HI/LO width; iteration count = WIDTH.
- CNT_WIDTH, 6, iteration counter width; must satisfy 2^CNT_WIDTH > WIDTH.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous, active-low
- ex_no_op  input  1  EX instruction is a bubble; ignore ex_md_op and ex_md_read
- ex_md_op  input  `MD_OP_WIDTH(3)  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE)
- ex_md_read  input  2  0 none, 1 MFHI, 2 MFLO, 3 reserved (treated as none)
- ex_operand_1  input  WIDTH  rs value: multiplicand, dividend, or MTHI/MTLO data
- ex_operand_2  input  WIDTH  rt value: multiplier or divisor
- md_busy  output  1  iterative operation in flight (registered)
- md_stall  output  1  to hazard_unit: hold ID/EX and earlier stages, insert bubble downstream
- md_read_data  output  WIDTH  HI for MFHI, LO for MFLO, 0 otherwise (combinational from registers)
- hi_out, lo_out  output  WIDTH  current HI/LO register values

Behaviour:
- Reset (async): state IDLE, md_busy=0, counter=0, HI=LO=0, all internal shift registers 0. Reset mid-operation aborts it; HI/LO are not updated.
- Valid op: ex_no_op=0 and ex_md_op in 1..6.
- States:
  - IDLE. On a valid op:
    - MULT/MULTU/DIV/DIVU: at the clock edge, capture operand magnitudes (signed ops) or raw values (unsigned ops) and the result-sign flags; counter<=0; go to BUSY.
    - MTHI/MTLO: at the clock edge, HI (or LO) <= ex_operand_1; stay IDLE.
  - BUSY. One radix-2 iteration per clock: shift-add for multiply, restoring subtract for divide; counter++.
    - On the edge where counter==WIDTH-1, apply sign fixup, write {HI,LO}, go to IDLE.
- Latency: op accepted in cycle 0; md_busy=1 in cycles 1..32; new HI/LO visible in cycle 33. MTHI/MTLO results are visible next cycle.
- The accepting instruction is not stalled; it leaves EX normally.
- md_stall = md_busy & ~ex_no_op & (valid op | ex_md_read!=0). It is combinational and deasserts in the first cycle with md_busy=0.
- While stalled, the waiting op is not accepted. It is accepted in the cycle md_busy falls, so back-to-back ops see no idle gap.
- Multiply result: {HI,LO} = 64-bit product. Signed ops negate the unsigned product if the operand signs differ.
- Divide result: LO = quotient, HI = remainder.
  - Signed: quotient is negative iff the operand signs differ; remainder takes the dividend's sign.
  - -2^31 / -1: LO=32'h8000_0000, HI=0.
  - Divide by zero (signed or unsigned): still takes 32 cycles; LO=32'hFFFF_FFFF, HI=dividend.
- MFHI/MFLO in EX while idle: md_read_data is valid in the same cycle. No bypass of in-flight results; the stall guarantees correctness.
- Reserved encodings are treated as NONE and never stall.

Decomposition:
- Shared definitions file: `MD_OP_WIDTH, `MD_OP_NONE..`MD_OP_MTLO, `MD_RD_NONE/`MD_RD_HI/`MD_RD_LO, and the state encodings MD_IDLE/MD_BUSY.
- One natural sub-module: md_iter_core, a combinational single-iteration step, mode-selected multiply or divide. The FSM, counter, sign fixup and HI/LO registers stay in ex_muldiv_unit.

Test Plan:
- MULT 0xFFFF_FFFE (-2) x 3 -> md_busy high cycles 1..32; cycle 33: HI=0xFFFF_FFFF, LO=0xFFFF_FFFA.
- MULTU 0xFFFF_FFFF x 0xFFFF_FFFF -> HI=0xFFFF_FFFE, LO=0x0000_0001.
- DIV -7 / 2 -> LO=0xFFFF_FFFD (-3), HI=0xFFFF_FFFF (-1). DIVU 7 / 0 -> LO=0xFFFF_FFFF, HI=7. DIV 0x8000_0000 / -1 -> LO=0x8000_0000, HI=0.
- DIVU 100/7, then MFLO in EX at cycle 1 -> md_stall=1 cycles 1..32 and 0 in cycle 33, where md_read_data=14. The same MFLO with ex_no_op=1 -> md_stall=0.
- MULT followed immediately by DIVU 9/4 (stalled) -> DIVU accepted in cycle 33; HI=1, LO=2 visible in cycle 66. MTHI 0x1234 while idle -> hi_out=0x1234 next cycle, no stall.
- rst_n low at cycle 10 of a DIV -> md_busy=0, HI=LO=0 immediately. A new MULTU 5x6 after release -> LO=30, HI=0 after 32 cycles.

Source files
------------

// File: rtl/ex_muldiv_unit_pkg.sv
// ex_muldiv_unit_pkg: shared opcode, read-select and state encodings for the EX mul/div unit
package ex_muldiv_unit_pkg;
  localparam int ISA_WIDTH = 32;
  localparam int MD_OP_WIDTH = 3;
  localparam logic [MD_OP_WIDTH-1:0] MD_OP_NONE  = 3'd0;
  localparam logic [MD_OP_WIDTH-1:0] MD_OP_MULT  = 3'd1;
  localparam logic [MD_OP_WIDTH-1:0] MD_OP_MULTU = 3'd2;
  localparam logic [MD_OP_WIDTH-1:0] MD_OP_DIV   = 3'd3;
  localparam logic [MD_OP_WIDTH-1:0] MD_OP_DIVU  = 3'd4;
  localparam logic [MD_OP_WIDTH-1:0] MD_OP_MTHI  = 3'd5;
  localparam logic [MD_OP_WIDTH-1:0] MD_OP_MTLO  = 3'd6;
  localparam logic [1:0] MD_RD_NONE = 2'd0;
  localparam logic [1:0] MD_RD_HI   = 2'd1;
  localparam logic [1:0] MD_RD_LO   = 2'd2;
  typedef enum logic {MD_IDLE = 1'b0, MD_BUSY = 1'b1} md_state_t;
  // Opcode 0 and the reserved opcode 7 behave as NONE.
  function automatic logic md_op_valid(input logic [MD_OP_WIDTH-1:0] op);
    return (op >= MD_OP_MULT) && (op <= MD_OP_MTLO);
  endfunction
endpackage

// File: rtl/ex_muldiv_unit_md_iter_core.sv
// md_iter_core: one radix-2 step, shift-add multiply or restoring divide on a {hi,lo} pair
module md_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             i_div,
  input  logic [WIDTH-1:0] i_hi,
  input  logic [WIDTH-1:0] i_lo,
  input  logic [WIDTH-1:0] i_op2,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;
  // Multiply: add the multiplicand when the multiplier LSB is set, then shift the pair right.
  assign w_sum   = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_op2} : '0);
  // Divide: shift the next dividend bit into the remainder and subtract when it fits.
  // A full-width compare keeps divide-by-zero yielding all-ones quotient and remainder = dividend.
  assign w_shift = {i_hi, i_lo[WIDTH-1]};
  assign w_ge    = w_shift >= {1'b0, i_op2};
  assign w_diff  = w_shift[WIDTH-1:0] - i_op2;
  assign o_hi    = i_div ? (w_ge ? w_diff : w_shift[WIDTH-1:0]) : w_sum[WIDTH:1];
  assign o_lo    = i_div ? {i_lo[WIDTH-2:0], w_ge} : {w_sum[0], i_lo[WIDTH-1:1]};
endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative MULT/MULTU/DIV/DIVU with HI/LO registers, MTHI/MTLO and stall request
module ex_muldiv_unit
  import ex_muldiv_unit_pkg::*;
#(
  parameter int WIDTH = ISA_WIDTH,
  parameter int CNT_WIDTH = 6
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ex_no_op,
  input  logic [MD_OP_WIDTH-1:0] ex_md_op,
  input  logic [1:0]             ex_md_read,
  input  logic [WIDTH-1:0]       ex_operand_1,
  input  logic [WIDTH-1:0]       ex_operand_2,
  output logic                   md_busy,
  output logic                   md_stall,
  output logic [WIDTH-1:0]       md_read_data,
  output logic [WIDTH-1:0]       hi_out,
  output logic [WIDTH-1:0]       lo_out
);
  md_state_t            r_state;
  logic                 r_busy;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic [WIDTH-1:0]     r_acc_hi;
  logic [WIDTH-1:0]     r_acc_lo;
  logic [WIDTH-1:0]     r_op2;
  logic                 r_div;
  logic                 r_neg_hi;
  logic                 r_neg_lo;
  logic                 w_valid;
  logic                 w_iter_op;
  logic                 w_is_div;
  logic                 w_signed;
  logic                 w_s1;
  logic                 w_s2;
  logic [WIDTH-1:0]     w_mag1;
  logic [WIDTH-1:0]     w_mag2;
  logic                 w_read_valid;
  logic                 w_last;
  logic [WIDTH-1:0]     w_step_hi;
  logic [WIDTH-1:0]     w_step_lo;
  logic [2*WIDTH-1:0]   w_prod;
  logic [2*WIDTH-1:0]   w_prod_fix;
  logic [WIDTH-1:0]     w_res_hi;
  logic [WIDTH-1:0]     w_res_lo;

  assign w_valid      = ~ex_no_op & md_op_valid(ex_md_op);
  assign w_iter_op    = w_valid & (ex_md_op <= MD_OP_DIVU);
  assign w_is_div     = (ex_md_op == MD_OP_DIV) | (ex_md_op == MD_OP_DIVU);
  assign w_signed     = (ex_md_op == MD_OP_MULT) | (ex_md_op == MD_OP_DIV);
  assign w_s1         = w_signed & ex_operand_1[WIDTH-1];
  assign w_s2         = w_signed & ex_operand_2[WIDTH-1];
  assign w_mag1       = w_s1 ? -ex_operand_1 : ex_operand_1;
  assign w_mag2       = w_s2 ? -ex_operand_2 : ex_operand_2;
  assign w_read_valid = (ex_md_read == MD_RD_HI) | (ex_md_read == MD_RD_LO);
  assign w_last       = r_cnt == CNT_WIDTH'(WIDTH - 1);

  md_iter_core #(.WIDTH(WIDTH)) u_core (
    .i_div (r_div),
    .i_hi  (r_acc_hi),
    .i_lo  (r_acc_lo),
    .i_op2 (r_op2),
    .o_hi  (w_step_hi),
    .o_lo  (w_step_lo)
  );

  // Sign fixup: the product negates as one double-width value, quotient and remainder independently.
  assign w_prod     = {w_step_hi, w_step_lo};
  assign w_prod_fix = r_neg_lo ? -w_prod : w_prod;
  assign w_res_hi   = r_div ? (r_neg_hi ? -w_step_hi : w_step_hi) : w_prod_fix[2*WIDTH-1:WIDTH];
  assign w_res_lo   = r_div ? (r_neg_lo ? -w_step_lo : w_step_lo) : w_prod_fix[WIDTH-1:0];

  assign md_busy      = r_busy;
  assign md_stall     = r_busy & ~ex_no_op & (md_op_valid(ex_md_op) | w_read_valid);
  assign md_read_data = (~ex_no_op & (ex_md_read == MD_RD_HI)) ? r_hi :
                        (~ex_no_op & (ex_md_read == MD_RD_LO)) ? r_lo : '0;
  assign hi_out       = r_hi;
  assign lo_out       = r_lo;

  // Control FSM: accept ops while idle, iterate while busy, commit HI/LO on the final step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= MD_IDLE;
      r_busy   <= 1'b0;
      r_cnt    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_op2    <= '0;
      r_div    <= 1'b0;
      r_neg_hi <= 1'b0;
      r_neg_lo <= 1'b0;
    end else if (r_state == MD_IDLE) begin
      if (w_iter_op) begin
        r_state  <= MD_BUSY;
        r_busy   <= 1'b1;
        r_cnt    <= '0;
        r_acc_hi <= '0;
        r_acc_lo <= w_mag1;
        r_op2    <= w_mag2;
        r_div    <= w_is_div;
        r_neg_hi <= w_is_div & w_s1;
        r_neg_lo <= (w_s1 ^ w_s2) & ~(w_is_div & (ex_operand_2 == '0));
      end else if (w_valid & (ex_md_op == MD_OP_MTHI)) begin
        r_hi <= ex_operand_1;
      end else if (w_valid & (ex_md_op == MD_OP_MTLO)) begin
        r_lo <= ex_operand_1;
      end
    end else begin
      r_acc_hi <= w_step_hi;
      r_acc_lo <= w_step_lo;
      r_cnt    <= r_cnt + 1'b1;
      if (w_last) begin
        r_hi    <= w_res_hi;
        r_lo    <= w_res_lo;
        r_state <= MD_IDLE;
        r_busy  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: vector table plus hand sequences for stall, back-to-back and reset behaviour
module tb_ex_muldiv_unit;
  import ex_muldiv_unit_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_no_op = 1'b1;
  logic [2:0]  ex_md_op = MD_OP_NONE;
  logic [1:0]  ex_md_read = MD_RD_NONE;
  logic [31:0] ex_operand_1 = '0;
  logic [31:0] ex_operand_2 = '0;
  logic        md_busy;
  logic        md_stall;
  logic [31:0] md_read_data;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } res_t;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  res_t exp_q[$];
  vec_t vecs[10];
  int   n_cmp = 0;
  int   n_bad = 0;

  ex_muldiv_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ex_no_op     (ex_no_op),
    .ex_md_op     (ex_md_op),
    .ex_md_read   (ex_md_read),
    .ex_operand_1 (ex_operand_1),
    .ex_operand_2 (ex_operand_2),
    .md_busy      (md_busy),
    .md_stall     (md_stall),
    .md_read_data (md_read_data),
    .hi_out       (hi_out),
    .lo_out       (lo_out)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (md_busy && n < 100) begin
      step();
      n++;
    end
  endtask

  task automatic check_result(input string name);
    res_t r;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: result produced with empty scoreboard", name);
    end else begin
      r = exp_q.pop_front();
      chk({name, " hi"}, hi_out, r.hi);
      chk({name, " lo"}, lo_out, r.lo);
    end
  endtask

  task automatic do_op(input string name, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] hi, input logic [31:0] lo);
    int n;
    step();
    ex_no_op = 1'b0;
    ex_md_op = op;
    ex_operand_1 = a;
    ex_operand_2 = b;
    exp_q.push_back('{hi, lo});
    step();
    ex_md_op = MD_OP_NONE;
    wait_idle(n);
    chk({name, " busy cycles"}, n, 32);
    check_result(name);
  endtask

  task automatic busy_run(input logic nop, input logic [2:0] op, input logic [1:0] rd,
                          output int s, output int n);
    ex_no_op = nop;
    ex_md_op = op;
    ex_md_read = rd;
    s = 0;
    n = 0;
    while (md_busy && n < 100) begin
      #1;
      if (md_stall) s++;
      step();
      n++;
    end
    #1;
  endtask

  initial begin
    int n;
    int s;
    vecs[0] = '{"mult_neg2x3",   MD_OP_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1] = '{"multu_max",     MD_OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{"div_m7_2",      MD_OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{"divu_7_0",      MD_OP_DIVU,  32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF};
    vecs[4] = '{"div_min_m1",    MD_OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000};
    vecs[5] = '{"divu_100_7",    MD_OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
    vecs[6] = '{"mult_max_min",  MD_OP_MULT,  32'h7FFF_FFFF, 32'h8000_0000, 32'hC000_0000, 32'h8000_0000};
    vecs[7] = '{"div_7_m2",      MD_OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
    vecs[8] = '{"div_m5_0",      MD_OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
    vecs[9] = '{"multu_2p16sq",  MD_OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'd1,         32'd0};

    repeat (3) step();
    chk("reset busy", {31'd0, md_busy}, 32'd0);
    chk("reset hi", hi_out, 32'd0);
    chk("reset lo", lo_out, 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 10; i++) do_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);

    step();
    ex_no_op = 1'b0;
    ex_md_op = MD_OP_DIVU;
    ex_operand_1 = 32'd100;
    ex_operand_2 = 32'd7;
    exp_q.push_back('{32'd2, 32'd14});
    step();
    busy_run(1'b0, MD_OP_NONE, MD_RD_LO, s, n);
    chk("mflo stall cycles", s, 32);
    chk("mflo release stall", {31'd0, md_stall}, 32'd0);
    chk("mflo read data", md_read_data, 32'd14);
    check_result("divu_mflo");
    ex_md_read = MD_RD_NONE;

    step();
    ex_no_op = 1'b0;
    ex_md_op = MD_OP_DIVU;
    exp_q.push_back('{32'd2, 32'd14});
    step();
    busy_run(1'b1, MD_OP_NONE, MD_RD_LO, s, n);
    chk("noop stall cycles", s, 0);
    chk("noop busy cycles", n, 32);
    check_result("divu_noop");

    step();
    ex_no_op = 1'b0;
    ex_md_op = MD_OP_DIVU;
    ex_md_read = MD_RD_NONE;
    exp_q.push_back('{32'd2, 32'd14});
    step();
    busy_run(1'b0, 3'd7, 2'd3, s, n);
    chk("reserved stall cycles", s, 0);
    check_result("divu_reserved");
    ex_md_op = MD_OP_NONE;
    ex_md_read = MD_RD_NONE;

    step();
    ex_no_op = 1'b0;
    ex_md_op = MD_OP_MULT;
    ex_operand_1 = 32'd3;
    ex_operand_2 = 32'd4;
    exp_q.push_back('{32'd0, 32'd12});
    step();
    ex_operand_1 = 32'd9;
    busy_run(1'b0, MD_OP_DIVU, MD_RD_NONE, s, n);
    chk("b2b stall cycles", s, 32);
    chk("b2b release stall", {31'd0, md_stall}, 32'd0);
    check_result("b2b_mult");
    exp_q.push_back('{32'd1, 32'd2});
    step();
    ex_md_op = MD_OP_NONE;
    chk("b2b divu accepted", {31'd0, md_busy}, 32'd1);
    wait_idle(n);
    chk("b2b divu busy cycles", n, 32);
    check_result("b2b_divu");

    step();
    ex_md_op = MD_OP_MTHI;
    ex_operand_1 = 32'h1234;
    #1;
    chk("mthi stall", {31'd0, md_stall}, 32'd0);
    step();
    ex_md_op = MD_OP_MTLO;
    ex_operand_1 = 32'hABCD;
    chk("mthi hi", hi_out, 32'h1234);
    step();
    ex_md_op = MD_OP_NONE;
    chk("mtlo lo", lo_out, 32'hABCD);
    ex_md_read = MD_RD_HI;
    #1;
    chk("mfhi idle", md_read_data, 32'h1234);
    ex_no_op = 1'b1;
    #1;
    chk("mfhi bubble", md_read_data, 32'd0);
    ex_no_op = 1'b0;
    ex_md_read = MD_RD_NONE;

    step();
    ex_md_op = MD_OP_DIV;
    ex_operand_1 = 32'hFFFF_FF9C;
    ex_operand_2 = 32'd3;
    step();
    ex_md_op = MD_OP_NONE;
    repeat (9) step();
    rst_n = 1'b0;
    #1;
    chk("abort busy", {31'd0, md_busy}, 32'd0);
    chk("abort hi", hi_out, 32'd0);
    chk("abort lo", lo_out, 32'd0);
    step();
    rst_n = 1'b1;
    do_op("multu_after_reset", MD_OP_MULTU, 32'd5, 32'd6, 32'd0, 32'd30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
